seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
- Drives the select input of the upstream 4:1 nibble mux.
- Takes the selected 4-bit digit back from the mux and decodes it to active-low segments.
- Drives the active-low anodes, with a one-cycle blanking gap between digits to prevent ghosting.
- Sits between the register/mux stage and the board display pins.

Parameters:
DIV_WIDTH, 16, width of the dwell prescaler; each digit is shown for 2^DIV_WIDTH cycles (minimum 2; minimum 3 when DISPLAY_DIM_EN is defined).

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  scan enable; 0 = all digits dark
digit_in  input  4  nibble from the upstream mux for the digit selected by sel
dp_in  input  4  decimal point per digit, 1 = lit; indexed by sel
digit_mask  input  4  per-digit blank, 1 = keep that digit dark
sel  output  2  select to the upstream mux; digit currently scanned
an  output  4  active-low anodes; an[i] drives digit i
seg  output  7  active-low segments {g,f,e,d,c,b,a}; seg[0] = a
dp  output  1  active-low decimal point
frame_done  output  1  one-cycle pulse after digit 3 completes its dwell

Behaviour:
- All outputs are registered.
- Reset values: cnt=0, sel=0, state=IDLE, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
- Reset overrides everything on the next edge, including mid-dwell.
- FSM states:
  - IDLE: an=1111, cnt=0, sel holds. If en=1, go to BLANK on the next edge.
  - BLANK: lasts exactly 1 cycle. an=1111. sel is already stable, so digit_in is valid. On the exiting edge: seg <= decode(digit_in), dp <= ~dp_in[sel], cnt <= 0. Go to SHOW.
  - SHOW: an = digit_mask[sel] ? 4'b1111 : ~(4'b0001 << sel). cnt increments each cycle. When cnt = all-ones: sel <= sel+1 (3 wraps to 0), cnt <= 0, an <= 1111, go to BLANK.
- Digit period is 2^DIV_WIDTH + 1 cycles; frame period is 4x that.
- seg and dp are latched only in BLANK. digit_in or dp_in changes during SHOW become visible on the next visit to that digit.
- frame_done = 1 for exactly the cycle after the SHOW->BLANK transition where sel wraps 3->0. It is 0 otherwise.
- en=0 in any state: go to IDLE on the next edge, with an=1111 and cnt=0. sel, seg and dp hold.
- Re-enabling resumes at the held sel via BLANK. frame_done is not asserted by disable or enable.
- Decode table (hex, active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Masked digits still consume their full dwell slot, so scan timing is independent of digit_mask.

Optional Feature:
DISPLAY_DIM_EN
- Defined: adds input port brightness[2:0]. In SHOW, the anode is driven only while cnt[DIV_WIDTH-1 -: 3] <= brightness; otherwise an=1111. brightness=7 means full on; 0 means 1/8 duty.
- Undefined: the port is absent and the anode is on for the whole SHOW state.
- Sel timing, seg/dp latching and frame_done are identical in both builds.

Test Plan:
All tests use DIV_WIDTH=2 (digit period 5 cycles) unless stated. The bench models the mux as digit_in = data[4*sel +: 4].
1. Reset: assert rst 2 cycles with en=1 -> an=1111, seg=1111111, dp=1, sel=0, frame_done=0; first non-BLANK an=1110 appears 2 cycles after rst release.
2. Scan: data=16'h8F1A, dp_in=4'b0010 -> SHOW sequence:
   - an=1110, seg=0001000
   - an=1101, seg=1111001, dp=0
   - an=1011, seg=0001110
   - an=0111, seg=0000000
   Each digit shows for 4 cycles, separated by 1 cycle with an=1111. frame_done pulses once per 20 cycles, one cycle after digit 3 ends.
3. Mask: digit_mask=4'b0100 -> an stays 1111 for the entire sel=2 slot; the other digits and the 20-cycle frame period are unchanged.
4. Disable mid-dwell: drop en at SHOW cycle 2 of sel=1 -> next edge an=1111, sel stays 1. Re-raise en -> BLANK, then a full 4-cycle SHOW of digit 1.
5. Reset mid-scan: rst at sel=2 SHOW -> next edge sel=0, an=1111, seg=1111111. Change digit_in during SHOW -> seg unchanged until the next BLANK.
6. DISPLAY_DIM_EN, DIV_WIDTH=4, brightness=1 -> within each 16-cycle SHOW, the anode is active for cnt 0..3 only (4 cycles). brightness=7 -> active all 16 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   en                scan enable; 0 = all digits dark, scan position held
//   digit_in[3:0]     nibble from the upstream mux for the digit chosen by sel
//   dp_in[3:0]        decimal point per digit, 1 = lit
//   digit_mask[3:0]   per-digit blank, 1 = keep that digit dark
//   brightness[2:0]   dwell duty control (only with DISPLAY_DIM_EN)
//   sel[1:0]          select to the upstream mux
//   an[3:0]           active-low anodes
//   seg[6:0]          active-low segments {g,f,e,d,c,b,a}
//   dp                active-low decimal point
//   frame_done        one-cycle pulse after digit 3 completes its dwell
// Optional feature macro: DISPLAY_DIM_EN adds brightness-based anode dimming.
module seg_scan_ctrl #(
   parameter int DIV_WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] digit_in,
   input  logic [3:0] dp_in,
   input  logic [3:0] digit_mask,
`ifdef DISPLAY_DIM_EN
   input  logic [2:0] brightness,
`endif
   output logic [1:0] sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
   state_t state, state_nxt;
   logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
   logic [1:0] sel_nxt;
   logic [3:0] an_nxt;
   logic [6:0] seg_nxt, dec;
   logic dp_nxt, fd_nxt, lit;
   always_comb begin
      case (digit_in)
         4'h0: dec = 7'b1000000;
         4'h1: dec = 7'b1111001;
         4'h2: dec = 7'b0100100;
         4'h3: dec = 7'b0110000;
         4'h4: dec = 7'b0011001;
         4'h5: dec = 7'b0010010;
         4'h6: dec = 7'b0000010;
         4'h7: dec = 7'b1111000;
         4'h8: dec = 7'b0000000;
         4'h9: dec = 7'b0010000;
         4'hA: dec = 7'b0001000;
         4'hB: dec = 7'b0000011;
         4'hC: dec = 7'b1000110;
         4'hD: dec = 7'b0100001;
         4'hE: dec = 7'b0000110;
         default: dec = 7'b0001110;
      endcase
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel_nxt   = sel;
      seg_nxt   = seg;
      dp_nxt    = dp;
      fd_nxt    = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = BLANK;
               cnt_nxt   = '0;
            end
            BLANK: begin
               // sel has been stable for a full cycle, so digit_in is settled here
               state_nxt = SHOW;
               cnt_nxt   = '0;
               seg_nxt   = dec;
               dp_nxt    = ~dp_in[sel];
            end
            SHOW: begin
               if (&cnt) begin
                  state_nxt = BLANK;
                  cnt_nxt   = '0;
                  sel_nxt   = sel + 2'd1;
                  fd_nxt    = (sel == 2'd3);
               end else begin
                  cnt_nxt = cnt + DIV_WIDTH'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
`ifdef DISPLAY_DIM_EN
   // top three counter bits give eight duty steps per dwell
   assign lit = cnt_nxt[DIV_WIDTH-1 -: 3] <= brightness;
`else
   assign lit = 1'b1;
`endif
   // anode is registered, so it is derived from the values the next cycle will hold
   assign an_nxt = (state_nxt == SHOW && !digit_mask[sel_nxt] && lit) ? ~(4'b0001 << sel_nxt) : 4'b1111;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel        <= 2'd0;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sel        <= sel_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_done <= fd_nxt;
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (reset, scan, mask, disable, mid-scan reset, decode sweep, dimming).
module tb_seg_scan_ctrl;
`ifdef DISPLAY_DIM_EN
   localparam int DW = 4;
`else
   localparam int DW = 2;
`endif
   localparam int P = 1 << DW;
   localparam int T = P + 1;
   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [1:0] sel;
      logic       fd;
   } exp_t;
   exp_t q[$];
   logic clk = 1'b0;
   logic rst, en;
   logic [15:0] data;
   logic [3:0] digit_in, dp_in, digit_mask;
`ifdef DISPLAY_DIM_EN
   logic [2:0] brightness;
`endif
   logic [1:0] sel;
   logic [3:0] an;
   logic [6:0] seg;
   logic dp, frame_done;
   int n = 0;
   int checks = 0;
   int failures = 0;
   logic [6:0] last_seg;
   logic last_dp;
   logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
   always #5 clk = ~clk;
   assign digit_in = data[4*sel +: 4];
   seg_scan_ctrl #(.DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .en(en), .digit_in(digit_in), .dp_in(dp_in), .digit_mask(digit_mask),
`ifdef DISPLAY_DIM_EN
      .brightness(brightness),
`endif
      .sel(sel), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );
   task automatic push(input int c, input logic [3:0] a, input logic [6:0] s, input logic d, input logic [1:0] sl, input logic f);
      exp_t e;
      e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.sel = sl; e.fd = f;
      q.push_back(e);
   endtask
   // one blank cycle then 'cnt' show cycles, the first 'on' of them with the anode lit
   task automatic slot(input int b, input logic [1:0] s, input logic [15:0] dat, input logic f, input int on, input int cnt);
      logic [6:0] sg;
      logic d;
      sg = dec[dat[4*s +: 4]];
      d = ~dp_in[s];
      push(b, 4'hf, last_seg, last_dp, s, f);
      for (int k = 0; k < cnt; k++) push(b + 1 + k, (k < on) ? ~(4'b0001 << s) : 4'hf, sg, d, s, 1'b0);
      last_seg = sg;
      last_dp = d;
   endtask
   task automatic frame(input int b, input logic f, input logic [15:0] dat, input logic [3:0] mk, input int on);
      for (int s = 0; s < 4; s++) slot(b + s * T, 2'(s), dat, (s == 0) ? f : 1'b0, mk[s] ? 0 : on, P);
   endtask
   task automatic wait_n(input int k);
      while (n < k) @(negedge clk);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         n++;
         while (q.size() > 0 && q[0].cyc < n) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_sample cyc=%0d", e.cyc);
         end
         if (q.size() > 0 && q[0].cyc == n) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, dp, sel, frame_done} !== {e.an, e.seg, e.dp, e.sel, e.fd}) begin
               failures++;
               $display("FAIL outputs cyc=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b expected an=%b seg=%b dp=%b sel=%0d fd=%b",
                        n, an, seg, dp, sel, frame_done, e.an, e.seg, e.dp, e.sel, e.fd);
            end
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog time limit reached at cyc=%0d", n);
      $fatal(1, "watchdog");
   end
   initial begin
      int b, b1, b2, r;
      rst = 1'b1; en = 1'b1; data = 16'h8F1A; dp_in = 4'b0010; digit_mask = 4'b0000;
`ifdef DISPLAY_DIM_EN
      brightness = 3'd7;
`endif
      last_seg = 7'b1111111;
      last_dp = 1'b1;
      push(1, 4'hf, 7'b1111111, 1'b1, 2'd0, 1'b0);
      push(2, 4'hf, 7'b1111111, 1'b1, 2'd0, 1'b0);
      wait_n(2);
      rst = 1'b0;
      b = 3;
      frame(b, 1'b0, 16'h8F1A, 4'b0000, P);
      frame(b + 4 * T, 1'b1, 16'h8F1A, 4'b0100, P);
      wait_n(b + 4 * T);
      digit_mask = 4'b0100;
      wait_n(b + 7 * T);
      digit_mask = 4'b0000;
      b += 8 * T;
      slot(b, 2'd0, 16'h8F1A, 1'b1, P, P);
      b1 = b + T;
      slot(b1, 2'd1, 16'h8F1A, 1'b0, P, 2);
      for (int k = 3; k < 6; k++) push(b1 + k, 4'hf, dec[1], 1'b0, 2'd1, 1'b0);
      slot(b1 + 6, 2'd1, 16'h8F1A, 1'b0, P, P);
      b2 = b1 + 6 + T;
      slot(b2, 2'd2, 16'h8F1A, 1'b0, P, 2);
      push(b2 + 3, 4'hf, 7'b1111111, 1'b1, 2'd0, 1'b0);
      last_seg = 7'b1111111;
      last_dp = 1'b1;
      r = b2 + 4;
      slot(r, 2'd0, 16'h8F1A, 1'b0, P, P);
      wait_n(b1 + 2);
      en = 1'b0;
      wait_n(b1 + 5);
      en = 1'b1;
      wait_n(b2 + 2);
      rst = 1'b1;
      wait_n(b2 + 3);
      rst = 1'b0;
      wait_n(r + 2);
      data = 16'h8F13;
      slot(r + T, 2'd1, 16'h8F13, 1'b0, P, P);
      slot(r + 2 * T, 2'd2, 16'h8F13, 1'b0, P, P);
      slot(r + 3 * T, 2'd3, 16'h8F13, 1'b0, P, P);
      frame(r + 4 * T, 1'b1, 16'h8F13, 4'b0000, P);
      b = r + 8 * T;
      for (int k = 0; k < 4; k++) begin
         wait_n(b - T + 1);
         data = sweep[k];
         frame(b, 1'b1, sweep[k], 4'b0000, P);
         b += 4 * T;
      end
`ifdef DISPLAY_DIM_EN
      wait_n(b - 1);
      frame(b, 1'b1, data, 4'b0000, P / 4);
      wait_n(b);
      brightness = 3'd1;
      b += 4 * T;
      wait_n(b - 1);
      frame(b, 1'b1, data, 4'b0000, P);
      wait_n(b);
      brightness = 3'd7;
      b += 4 * T;
`endif
      wait_n(b + 1);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL leftover_expectations got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
